// File: rtl/bmult_share_pkg.sv
// bmult_share_pkg: shared constants and tag type for the shared-multiplier arbiter.
package bmult_share_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 24;
  localparam int DEF_LAT   = 1;
  localparam int IDX_W     = 8;
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;
endpackage

// File: rtl/bmult_rr_arb.sv
// bmult_rr_arb: round-robin selector; search starts at ptr_i, returns one-hot grant and index.
module bmult_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);
  int j;
  // Walk the search order backwards so the last hit is the first eligible after the pointer.
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (elig_i[j]) begin
        grant_o = '0;
        grant_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bmult_share_arb.sv
// bmult_share_arb: shares one external multiplier among NREQ requesters with round-robin grant.
// Optional accept counter port ops_cnt when BMULT_SHARE_ARB_STATS_EN is defined.
module bmult_share_arb
  import bmult_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [NREQ*2*WIDTH-1:0]   rsp_p,
  output logic [WIDTH-1:0]          mul_a,
  output logic [WIDTH-1:0]          mul_b,
  input  logic [2*WIDTH-1:0]        mul_p
`ifdef BMULT_SHARE_ARB_STATS_EN
  ,output logic [31:0]              ops_cnt
`endif
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int PW = 2 * WIDTH;
  logic [NREQ-1:0] elig, grant, cap, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] gidx, ptr_q, ptr_d;
  logic [NREQ*PW-1:0] rsp_p_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;
  tag_t tag_q [LAT+1];
  logic acc;
  assign elig = req_valid & ~busy_q & ~rsp_valid_q;
  bmult_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (gidx)
  );
  // Grant is held off while reset is asserted even though eligibility is combinational.
  assign req_ready = grant & {NREQ{rst_n}};
  assign acc = |(req_ready & req_valid);
  always_comb begin
    cap = '0;
    ptr_d = acc ? (gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
    for (int i = 0; i < NREQ; i++) cap[i] = tag_q[LAT].valid && tag_q[LAT].idx == idx_t'(i);
    busy_d = (busy_q | (acc ? grant : '0)) & ~cap;
    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      busy_q <= '0;
      rsp_valid_q <= '0;
      rsp_p_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      if (acc) begin
        mul_a_q <= req_a[gidx*WIDTH +: WIDTH];
        mul_b_q <= req_b[gidx*WIDTH +: WIDTH];
      end
      tag_q[0] <= {acc, idx_t'(gidx)};
      for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
      // Tail of the tag pipeline lines up with the cycle after mul_p became valid.
      if (tag_q[LAT].valid) rsp_p_q[tag_q[LAT].idx*PW +: PW] <= mul_p;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_p = rsp_p_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
`ifdef BMULT_SHARE_ARB_STATS_EN
  logic [31:0] ops_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_q <= '0;
    else if (acc && ops_q != '1) ops_q <= ops_q + 1'b1;
  end
  assign ops_cnt = ops_q;
`endif
endmodule

// File: doc/bmult_share_arb.md
BMULT_SHARE_ARB -- requirements
Module: bmult_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-002 SHALL have parameter WIDTH, default 24: operand width; product width is 2*WIDTH.
REQ-003 SHALL have parameter LAT, default 1: multiplier latency in clock edges, always >= 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester operand valid.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester grant; req_valid & req_ready at an edge is an accept.
REQ-008 SHALL have port req_a, input, NREQ x WIDTH: operand A per requester.
REQ-009 SHALL have port req_b, input, NREQ x WIDTH: operand B per requester.
REQ-010 SHALL have port rsp_valid, output, NREQ: result held for requester.
REQ-011 SHALL have port rsp_ready, input, NREQ: requester consumes its result.
REQ-012 SHALL have port rsp_p, output, NREQ x 2*WIDTH: held product per requester.
REQ-013 SHALL have port mul_a, output, WIDTH: registered operand A to the external multiplier.
REQ-014 SHALL have port mul_b, output, WIDTH: registered operand B to the external multiplier.
REQ-015 SHALL have port mul_p, input, 2*WIDTH: multiplier product.

Function
REQ-016 SHALL accept at most one request per cycle.
REQ-017 SHALL make requester i eligible when req_valid[i]=1, it has no operation in flight, and rsp_valid[i]=0.
REQ-018 SHALL arbitrate eligible requesters round-robin; the search starts at the pointer.
REQ-019 SHALL move the pointer to (granted index + 1) mod NREQ after each accept, and hold it otherwise.
REQ-020 SHALL drive req_ready combinationally as a one-hot or zero vector; req_ready[i] may depend on req_valid[i].
REQ-021 SHALL load mul_a and mul_b with the accepted operands at the accept edge E0, and hold them when there is no accept.
REQ-022 SHALL carry a valid bit and requester index through a tag pipeline of depth LAT+1 started at E0.
REQ-023 SHALL treat mul_p as valid after edge E0+LAT, capture it into rsp_p[i] at edge E0+LAT+1, and set rsp_valid[i] at that same edge.
REQ-024 SHALL give a throughput of one accept per cycle when accepts come from different requesters.
REQ-025 SHALL keep rsp_valid[i] and rsp_p[i] stable until rsp_valid[i] & rsp_ready[i] at an edge, which clears rsp_valid[i].
REQ-026 SHALL allow requester i to be eligible no earlier than the cycle after its result is consumed; a consume and a re-accept never share an edge.
REQ-027 SHALL ignore rsp_ready[i] while rsp_valid[i]=0.
REQ-028 SHALL compute the product as unsigned, WIDTH x WIDTH -> 2*WIDTH, with no truncation.

Reset
REQ-029 SHALL, while rst_n=0: clear rsp_valid, req_ready, rsp_p, mul_a, mul_b, the tag pipeline and the stats counter, and set the pointer to 0.
REQ-030 SHALL discard in-flight operations on a reset mid-operation; no rsp_valid is raised for them after release.
REQ-031 SHALL permit the first accept at the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with BMULT_SHARE_ARB_STATS_EN defined, add output port ops_cnt, 32 bits: saturating count of accepts, cleared by reset.
REQ-033 SHALL, without BMULT_SHARE_ARB_STATS_EN, have no ops_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-034 SHALL define the default width and latency constants and the tag struct (valid, index) in package bmult_share_pkg.
REQ-035 SHALL place round-robin selection in sub-module bmult_rr_arb: inputs eligible vector and pointer; outputs one-hot grant and granted index.
REQ-036 SHALL instantiate no multiplier; the integrator connects mul_a, mul_b and mul_p to Bmult24x24 with LAT=1.

Verification
REQ-037 SHALL cover a single request: requester 2 accepts A=0x000003, B=0x000005 at E0 -> rsp_valid[2] rises at E0+2 (LAT=1), rsp_p[2]=0x00000000000F.
REQ-038 SHALL cover all four requesters valid continuously from reset -> grants go 0,1,2,3 on consecutive edges; each product returns to the matching index.
REQ-039 SHALL cover the maximum operands: A=B=0xFFFFFF -> rsp_p=0xFFFFFE000001.
REQ-040 SHALL cover back-pressure: rsp_ready[1]=0 for 10 cycles -> req_ready[1] stays 0, rsp_p[1] stays stable, and other requesters continue to be served.
REQ-041 SHALL cover a reset mid-flight: rst_n pulses low one edge after an accept -> no rsp_valid follows, and the pointer is back at 0.
REQ-042 SHALL cover the stats counter with BMULT_SHARE_ARB_STATS_EN defined: 100 accepts -> ops_cnt=100.
